// File: rtl/muladd_pkg.sv
// Shared constants and the saturation helper for the muladd_pipe DSP BEL.
package muladd_pkg;

    localparam int unsigned NoConfigBits   = 6;
    localparam int unsigned CFG_IN_REG     = 0;
    localparam int unsigned CFG_PROD_REG   = 1;
    localparam int unsigned CFG_ACC_MODE   = 2;
    localparam int unsigned CFG_SIGNED     = 3;
    localparam int unsigned CFG_Q_FROM_ACC = 4;
    localparam int unsigned CFG_SATURATE   = 5;

    // Widest accumulator the clamp helper supports; callers zero-extend into it.
    localparam int unsigned SAT_MAX_W = 63;
    localparam int unsigned SAT_IDX_W = 6;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] value;
    } sat_res_t;

    // sum_ext holds a (width+1)-bit sum of two operands already extended to width+1 bits.
    // Bit [width] is the carry (unsigned) or the true sign (signed).
    function automatic sat_res_t sat_clamp(input logic [SAT_MAX_W:0] sum_ext,
                                           input logic               signed_mode,
                                           input int unsigned        width);
        sat_res_t             r;
        logic                 top;
        logic                 msb;
        logic [SAT_MAX_W-1:0] mask;
        top     = sum_ext[SAT_IDX_W'(width)];
        msb     = sum_ext[SAT_IDX_W'(width - 1)];
        mask    = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
        r.ovf   = signed_mode ? (top ^ msb) : top;
        r.value = sum_ext[SAT_MAX_W-1:0] & mask;
        if (r.ovf) begin
            if (!signed_mode) begin
                r.value = mask;
            end else if (top) begin
                r.value = mask & ~(mask >> 1);
            end else begin
                r.value = mask >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/muladd_if.sv
// Operand/result bundle of the muladd_pipe BEL as seen from the switch matrix.
interface muladd_if #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH = 20
);
    logic [A_WIDTH-1:0]   A;
    logic [B_WIDTH-1:0]   B;
    logic [ACC_WIDTH-1:0] C;
    logic                 in_valid;
    logic                 acc_load;
    logic [ACC_WIDTH-1:0] Q;
    logic                 out_valid;
    logic                 ovf;

    modport master (output A, B, C, in_valid, acc_load, input Q, out_valid, ovf);
    modport slave  (input A, B, C, in_valid, acc_load, output Q, out_valid, ovf);
endinterface

// File: rtl/muladd_addsat.sv
// Combinational extend/add/overflow/clamp stage; owns every width and sign rule.
module muladd_addsat
    import muladd_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 20
) (
    input  logic [PROD_WIDTH-1:0] prod,
    input  logic [ACC_WIDTH-1:0]  addend,
    input  logic                  signed_mode,
    input  logic                  saturate,
    output logic [ACC_WIDTH-1:0]  result_c,
    output logic                  ovf_c
);

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum;
    sat_res_t             sat;
    logic                 sat_hi_unused;

    // Both operands are extended to ACC_WIDTH+1 so the top bit carries the true sign/carry.
    always_comb begin
        prod_ext = '0;
        sum      = '0;
        if (signed_mode) begin
            prod_ext = ACC_WIDTH'($signed(prod));
            sum      = (ACC_WIDTH+1)'($signed(prod_ext)) + (ACC_WIDTH+1)'($signed(addend));
        end else begin
            prod_ext = ACC_WIDTH'(prod);
            sum      = (ACC_WIDTH+1)'(prod_ext) + (ACC_WIDTH+1)'(addend);
        end
        sat      = sat_clamp((SAT_MAX_W+1)'(sum), signed_mode, ACC_WIDTH);
        ovf_c    = sat.ovf;
        result_c = (saturate && sat.ovf) ? sat.value[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
    end

    assign sat_hi_unused = ^sat.value[SAT_MAX_W-1:ACC_WIDTH];

endmodule

// File: rtl/muladd_pipe.sv
// Configurable multiply-add BEL: Q = A*B + (C or ACC) with optional input/product
// registers, signed mode, accumulator, saturation and sticky overflow.
module muladd_pipe
    import muladd_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic                    UserCLK,
    input  logic                    clr,
    input  logic [NoConfigBits-1:0] ConfigBits,
    muladd_if.slave                 bus
);

    localparam int unsigned PROD_WIDTH = A_WIDTH + B_WIDTH;

    logic cfg_in_reg, cfg_prod_reg, cfg_acc_mode, cfg_signed, cfg_q_from_acc, cfg_saturate;

    assign cfg_in_reg     = ConfigBits[CFG_IN_REG];
    assign cfg_prod_reg   = ConfigBits[CFG_PROD_REG];
    assign cfg_acc_mode   = ConfigBits[CFG_ACC_MODE];
    assign cfg_signed     = ConfigBits[CFG_SIGNED];
    assign cfg_q_from_acc = ConfigBits[CFG_Q_FROM_ACC];
    assign cfg_saturate   = ConfigBits[CFG_SATURATE];

    logic [A_WIDTH-1:0]    s0_a_q, s0_a;
    logic [B_WIDTH-1:0]    s0_b_q, s0_b;
    logic [ACC_WIDTH-1:0]  s0_c_q, s0_c;
    logic                  s0_valid_q, s0_valid, s0_load_q, s0_load;
    logic [PROD_WIDTH-1:0] a_ext, b_ext, prod_c;
    logic [PROD_WIDTH-1:0] s1_prod_q, s1_prod;
    logic [ACC_WIDTH-1:0]  s1_c_q, s1_c;
    logic                  s1_valid_q, s1_valid, s1_load_q, s1_load;
    logic [ACC_WIDTH-1:0]  addend_c, result_c, acc_q;
    logic                  ovf_c, ovf_q, qv_q;

    // S0: operand capture
    always_ff @(posedge UserCLK) begin
        if (clr) begin
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s0_c_q     <= '0;
            s0_valid_q <= 1'b0;
            s0_load_q  <= 1'b0;
        end else begin
            s0_a_q     <= bus.A;
            s0_b_q     <= bus.B;
            s0_c_q     <= bus.C;
            s0_valid_q <= bus.in_valid;
            s0_load_q  <= bus.acc_load;
        end
    end

    always_comb begin
        s0_a     = bus.A;
        s0_b     = bus.B;
        s0_c     = bus.C;
        s0_valid = bus.in_valid;
        s0_load  = bus.acc_load;
        if (cfg_in_reg) begin
            s0_a     = s0_a_q;
            s0_b     = s0_b_q;
            s0_c     = s0_c_q;
            s0_valid = s0_valid_q;
            s0_load  = s0_load_q;
        end
    end

    // Operands are extended to the product width so the low bits are exact in either mode.
    always_comb begin
        a_ext = PROD_WIDTH'(s0_a);
        b_ext = PROD_WIDTH'(s0_b);
        if (cfg_signed) begin
            a_ext = PROD_WIDTH'($signed(s0_a));
            b_ext = PROD_WIDTH'($signed(s0_b));
        end
        prod_c = a_ext * b_ext;
    end

    // S1: product capture with its tags
    always_ff @(posedge UserCLK) begin
        if (clr) begin
            s1_prod_q  <= '0;
            s1_c_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_load_q  <= 1'b0;
        end else begin
            s1_prod_q  <= prod_c;
            s1_c_q     <= s0_c;
            s1_valid_q <= s0_valid;
            s1_load_q  <= s0_load;
        end
    end

    always_comb begin
        s1_prod  = prod_c;
        s1_c     = s0_c;
        s1_valid = s0_valid;
        s1_load  = s0_load;
        if (cfg_prod_reg) begin
            s1_prod  = s1_prod_q;
            s1_c     = s1_c_q;
            s1_valid = s1_valid_q;
            s1_load  = s1_load_q;
        end
        addend_c = (cfg_acc_mode && !s1_load) ? acc_q : s1_c;
    end

    muladd_addsat #(
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_addsat (
        .prod        (s1_prod),
        .addend      (addend_c),
        .signed_mode (cfg_signed),
        .saturate    (cfg_saturate),
        .result_c    (result_c),
        .ovf_c       (ovf_c)
    );

    // ACC follows every valid result, even when it is not used as the addend.
    always_ff @(posedge UserCLK) begin
        if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            qv_q  <= 1'b0;
        end else begin
            qv_q <= s1_valid;
            if (s1_valid) begin
                acc_q <= result_c;
                if (ovf_c) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Q         = cfg_q_from_acc ? acc_q : result_c;
    assign bus.out_valid = !clr && (cfg_q_from_acc ? qv_q : s1_valid);
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_muladd_pipe.sv
// Self-checking bench for muladd_pipe: directed plan steps followed by randomized traffic
// against an integer-arithmetic reference model with a per-cycle expectation history.
module tb_muladd_pipe;

    localparam int unsigned AW = 8;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 20;
    localparam int unsigned HN = 2048;

    logic       clk = 1'b0;
    logic       clr;
    logic [5:0] cfg;

    always #5 clk = ~clk;

    muladd_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) bus ();

    muladd_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) dut (
        .UserCLK    (clk),
        .clr        (clr),
        .ConfigBits (cfg),
        .bus        (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 4;

    bit [CW-1:0] acc_m;
    bit          ovf_m;
    bit          hist_v   [HN];
    bit [CW-1:0] hist_res [HN];
    bit [CW-1:0] hist_acc [HN];
    bit          hist_ovf [HN];

    logic [CW-1:0] q_s;
    logic          v_s;
    logic          o_s;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s at cycle %0d: observed %h expected %h", tag, t, got, exp);
    endtask

    // Reference: exact integer arithmetic, then range test against the ACC_WIDTH format.
    task automatic model_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic [CW-1:0] c, input logic ld, output bit [CW-1:0] res);
        longint      pa, pb, ad, s, hi, lo;
        bit [CW-1:0] addend;
        addend = (cfg[2] && !ld) ? acc_m : c;
        if (cfg[3]) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            ad = longint'($signed(addend));
            hi = (longint'(1) << (CW - 1)) - 1;
            lo = -(longint'(1) << (CW - 1));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
            ad = longint'(addend);
            hi = (longint'(1) << CW) - 1;
            lo = 0;
        end
        s = pa * pb + ad;
        if (s > hi || s < lo) begin
            ovf_m = 1'b1;
            if (cfg[5]) s = (s > hi) ? hi : lo;
        end
        res   = CW'(s);
        acc_m = res;
    endtask

    // One clock: drive, update the model, sample mid-cycle, compare against history.
    task automatic cyc(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [CW-1:0] c,
                       input logic v, input logic ld, input logic rs);
        int          lat, dly;
        logic        exp_v;
        bit [CW-1:0] r;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        bus.in_valid = v;
        bus.acc_load = ld;
        clr          = rs;
        dly = int'(cfg[0]) + int'(cfg[1]);
        lat = dly + int'(cfg[4]);
        if (!rs) begin
            r = '0;
            if (v) model_op(a, b, c, ld, r);
            hist_v[t]   = v;
            hist_res[t] = r;
            hist_acc[t] = acc_m;
            hist_ovf[t] = ovf_m;
        end
        #4;
        q_s = bus.Q;
        v_s = bus.out_valid;
        o_s = bus.ovf;
        exp_v = rs ? 1'b0 : hist_v[t-lat];
        check("out_valid", CW'(v_s), CW'(exp_v));
        check("ovf", CW'(o_s), CW'(hist_ovf[t-dly-1]));
        if (cfg[4]) check("q_acc", q_s, hist_acc[t-lat]);
        else if (exp_v) check("q_result", q_s, hist_res[t-lat]);
        if (rs) begin
            acc_m = '0;
            ovf_m = 1'b0;
            for (int j = 0; j < 4; j++) begin
                hist_v[t-j]   = 1'b0;
                hist_res[t-j] = '0;
                hist_acc[t-j] = '0;
                hist_ovf[t-j] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic reconfig(input logic [5:0] nc);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b1);
        cfg = nc;
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        cfg          = 6'b000000;
        clr          = 1'b1;
        bus.A        = '0;
        bus.B        = '0;
        bus.C        = '0;
        bus.in_valid = 1'b0;
        bus.acc_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_ovf", CW'(o_s), '0);

        // Unsigned, fully combinational
        cyc(8'd200, 8'd100, 20'd5, 1'b1, 1'b0, 1'b0);
        check("umul_q", q_s, 20'd20005);
        check("umul_v", CW'(v_s), CW'(1'b1));

        // Signed with both stage registers: reset Q and two-cycle latency
        reconfig(6'b001011);
        check("rst_q_regs", q_s, '0);
        cyc(8'hFD, 8'd7, 20'd10, 1'b1, 1'b0, 1'b0);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("smul_early_v", CW'(v_s), '0);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("smul_q", q_s, 20'hFFFF5);
        check("smul_v", CW'(v_s), CW'(1'b1));
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("smul_single_pulse", CW'(v_s), '0);

        // Accumulate from ACC with a bubble
        reconfig(6'b010100);
        cyc(8'd2, 8'd3, 20'd0, 1'b1, 1'b1, 1'b0);
        cyc(8'd4, 8'd5, 20'd0, 1'b1, 1'b0, 1'b0);
        check("acc_q0", q_s, 20'd6);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("acc_q1", q_s, 20'd26);
        cyc(8'd1, 8'd1, 20'd0, 1'b1, 1'b0, 1'b0);
        check("acc_bubble_q", q_s, 20'd26);
        check("acc_bubble_v", CW'(v_s), '0);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("acc_q3", q_s, 20'd27);

        // Signed saturation then signed wrap
        reconfig(6'b111100);
        cyc('0, '0, 20'h7FF00, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(8'd127, 8'd127, '0, 1'b1, 1'b0, 1'b0);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("ssat_q", q_s, 20'h7FFFF);
        check("ssat_ovf", CW'(o_s), CW'(1'b1));
        reconfig(6'b011100);
        cyc('0, '0, 20'h7FF00, 1'b1, 1'b1, 1'b0);
        cyc(8'd127, 8'd127, '0, 1'b1, 1'b0, 1'b0);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("swrap_q", q_s, 20'h83E01);
        check("swrap_ovf", CW'(o_s), CW'(1'b1));

        // Unsigned saturation, then clr clears ovf and ACC
        reconfig(6'b100000);
        cyc(8'd1, 8'd1, 20'hFFFFF, 1'b1, 1'b0, 1'b0);
        check("usat_q", q_s, 20'hFFFFF);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("usat_ovf", CW'(o_s), CW'(1'b1));
        reconfig(6'b110000);
        cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("clr_ovf", CW'(o_s), '0);
        check("clr_acc", q_s, '0);

        // clr in the middle of a full pipeline discards in-flight work
        reconfig(6'b010111);
        cyc(8'd3, 8'd3, 20'd0, 1'b1, 1'b1, 1'b0);
        cyc(8'd2, 8'd2, 20'd0, 1'b1, 1'b0, 1'b0);
        cyc(8'd5, 8'd5, 20'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc('0, '0, '0, 1'b0, 1'b0, 1'b0);
            check("midclr_no_v", CW'(v_s), '0);
        end
        check("midclr_acc", q_s, '0);
        check("midclr_ovf", CW'(o_s), '0);

        // Randomized configurations and traffic, with occasional clr
        for (int k = 0; k < 8; k++) begin
            reconfig(6'($urandom_range(0, 63)));
            for (int i = 0; i < 60; i++) begin
                cyc(AW'($urandom), BW'($urandom), CW'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 49) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muladd_pipe.md
Name: muladd_pipe

Overview:
Parametrised successor to the fabric DSP multiply-add BEL: Q = A*B + (C or accumulator), with configurable operand widths. Adds:
- a valid-tagged, optionally pipelined datapath
- a runtime signed/unsigned mode
- accumulator hold and load
- optional saturation with a sticky overflow flag

Sits in DSP tiles as a BEL. Data/control pins go to the switch matrix; ConfigBits come from the tile configuration chain.

Parameters:
A_WIDTH, 8, operand A width (>=2)
B_WIDTH, 8, operand B width (>=2)
ACC_WIDTH, 20, addend/accumulator/result width; must be >= A_WIDTH+B_WIDTH
NoConfigBits, 6, configuration bit count (fixed at 6 for this BEL)

Ports:
UserCLK  in  1  user clock (EXTERNAL, SHARED_PORT)
clr  in  1  synchronous active-high reset of all state
A  in  A_WIDTH  multiplicand
B  in  B_WIDTH  multiplier
C  in  ACC_WIDTH  addend / accumulator load value
in_valid  in  1  operands valid this cycle
acc_load  in  1  with in_valid in accumulate mode: addend = C instead of ACC
Q  out  ACC_WIDTH  result
out_valid  out  1  Q holds a valid result
ovf  out  1  sticky overflow flag
ConfigBits  in  NoConfigBits  GLOBAL config: [0] IN_REG, [1] PROD_REG, [2] ACC_MODE, [3] SIGNED, [4] Q_FROM_ACC, [5] SATURATE

Behaviour:
- One clock, UserCLK. Reset is clr: synchronous, active-high, and wins over every other event in the same cycle.
- On clr, all registers go to 0: input stage, product stage, ACC, valid pipeline, ovf. While clr is high, out_valid is forced to 0.
- ConfigBits are static; they may change only while clr is held.
- Stage S0 (IN_REG=1): A, B, C, in_valid, acc_load are registered together; otherwise they pass through combinationally.
- Stage S1 (PROD_REG=1): the product (A_WIDTH+B_WIDTH bits) is registered together with its C, valid and acc_load tags; otherwise combinational.
- Product extension to ACC_WIDTH:
  - SIGNED=1: operands are two's complement; the product is sign-extended.
  - SIGNED=0: unsigned; the product is zero-extended.
- Addend selection:
  - ACC_MODE=0: addend = C.
  - ACC_MODE=1: addend = C when acc_load tag = 1, else ACC.
- Sum width and overflow:
  - The sum is formed at ACC_WIDTH+1 bits.
  - Overflow, unsigned: carry out.
  - Overflow, signed: both operands share a sign and the result sign differs.
- On overflow:
  - SATURATE=1: result clamps. Unsigned clamps to all-ones. Signed clamps to 0111..1 (positive overflow) or 1000..0 (negative overflow).
  - SATURATE=0: result wraps modulo 2^ACC_WIDTH.
  - ovf sets on any overflow of a valid operation, regardless of SATURATE, and clears only on clr.
- Accumulator:
  - ACC <= result only on cycles where the S1 valid tag = 1; otherwise ACC holds.
  - ACC always tracks valid results, including when ACC_MODE=0.
- Output:
  - Q_FROM_ACC=0: Q = result (combinational from S1); out_valid = S1 valid tag.
  - Q_FROM_ACC=1: Q = ACC; out_valid = S1 valid tag delayed one cycle, registered.
- Latency from in_valid to out_valid = IN_REG + PROD_REG + Q_FROM_ACC cycles (0..3).
- Throughput is one operation per cycle. There is no backpressure; results are never dropped or stalled.
- Bubbles (in_valid=0) do not disturb ACC. Invalid slots leave Q at a don't-care value, except with Q_FROM_ACC=1, where Q holds ACC.
- Reset values: Q = 0 when Q_FROM_ACC=1 or both stage registers are enabled; out_valid = 0; ovf = 0.
- If clr is asserted mid-pipeline, all in-flight operations are discarded; no out_valid pulses for them appear afterwards.

Decomposition:
- Shared package muladd_pkg:
  - ConfigBits index constants (CFG_IN_REG=0 … CFG_SATURATE=5)
  - NoConfigBits constant
  - function sat_clamp(sum_ext, signed_mode) returning clamped value plus overflow flag
- One natural sub-module: muladd_addsat. It is combinational: extend, add, detect overflow, clamp. It holds all width/sign rules so the top-level module only handles pipeline registers and muxing.

Test Plan:
- Unsigned, all registers off, ACC_MODE=0: A=200, B=100, C=5 -> Q=20005 and out_valid in the same cycle; ovf=0.
- Signed, IN_REG=PROD_REG=1: A=-3 (8'hFD), B=7, C=10 -> after 2 cycles Q=-11 (20'hFFFF5), out_valid pulses once.
- Accumulate, Q_FROM_ACC=1: acc_load with C=0 and A=2,B=3; then A=4,B=5; then a bubble; then A=1,B=1 -> Q sequence 6, 26, 26, 27. out_valid is high only for the three valid operations; ACC holds 26 through the bubble.
- Saturation, signed, SATURATE=1: ACC loaded to 0x7FF00, then repeated A=127,B=127 -> Q clamps at 0x7FFFF, ovf=1. Rerun with SATURATE=0: Q wraps negative, ovf=1.
- Unsigned saturation: C=0xFFFFF, A=B=1 -> Q=0xFFFFF, ovf=1. clr then resets ovf=0 and ACC=0.
- Reset mid-operation: all stages enabled, three valid inputs, clr asserted on cycle 2 together with in_valid -> no out_valid pulses follow, ACC=0, ovf=0.
